// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter in front of a single-port word RAM.
// One transaction at a time: grant in IDLE, strobe RAM in ACCESS, ack in RESP.
module dm_arbiter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_byteen,
  output logic [31:0]       m0_rdata,
  output logic              m0_ack,

  input  logic              m1_req,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_byteen,
  output logic [31:0]       m1_rdata,
  output logic              m1_ack,

  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              last_grant;
  logic              win_q;
  logic              in_range_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        byteen_q;

  logic              grant;
  logic              win_idx;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_byteen;
  logic              sel_in_range;
  logic [31:0]       resp_rdata;
  logic              unused_addr_bits;

  // Round-robin: on a tie the master not granted last wins.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win_idx   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant     = 1'b1;
          state_nxt = ACCESS;
          if (m0_req && m1_req) win_idx = ~last_grant;
          else                  win_idx = m1_req;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel_addr   = win_idx ? m1_addr   : m0_addr;
    sel_wdata  = win_idx ? m1_wdata  : m0_wdata;
    sel_byteen = win_idx ? m1_byteen : m0_byteen;
  end

  assign sel_in_range     = (sel_addr[31:ADDR_W+2] == '0);
  assign unused_addr_bits = ^sel_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win_q      <= 1'b0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      byteen_q   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= win_idx;
        win_q      <= win_idx;
        in_range_q <= sel_in_range;
        addr_q     <= sel_addr[ADDR_W+1:2];
        wdata_q    <= sel_wdata;
        byteen_q   <= sel_byteen;
      end
    end
  end

  // Address and write data simply follow the latched request; only the
  // strobes are qualified by state, so an aborted access leaves them idle.
  always_comb begin
    ram_en    = (state == ACCESS) && in_range_q;
    ram_we    = ram_en ? byteen_q : 4'b0000;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
  end

  always_comb begin
    resp_rdata = '0;
    if ((state == RESP) && in_range_q && (byteen_q == 4'b0000))
      resp_rdata = ram_rdata;
  end

  always_comb begin
    m0_ack   = (state == RESP) && !win_q;
    m1_ack   = (state == RESP) &&  win_q;
    m0_rdata = m0_ack ? resp_rdata : 32'h0;
    m1_rdata = m1_ack ? resp_rdata : 32'h0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written corner sequences,
// then random two-master traffic against a transaction-level reference.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        ram_en;
  logic [11:0] ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side RAM: registered read, byte-enable writes.
  bit [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit mst, input logic rq, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (!mst) begin
      m0_req = rq; m0_addr = a; m0_wdata = wd; m0_byteen = be;
    end else begin
      m1_req = rq; m1_addr = a; m1_wdata = wd; m1_byteen = be;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  typedef struct {
    bit          mst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_en;
    logic [11:0] exp_addr;
    logic [3:0]  exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive(v.mst, 1'b1, v.addr, v.wdata, v.be);
    @(negedge clk);
    chk({p, "_ack_early"}, {30'b0, m1_ack, m0_ack}, 32'h0);
    chk({p, "_ram_en"}, ram_en, v.exp_en);
    chk({p, "_ram_we"}, ram_we, v.exp_we);
    if (v.exp_en) chk({p, "_ram_addr"}, ram_addr, v.exp_addr);
    if (v.exp_en && v.be != 4'b0) chk({p, "_ram_wdata"}, ram_wdata, v.wdata);
    @(negedge clk);
    chk({p, "_ack"},        v.mst ? m1_ack : m0_ack, 1'b1);
    chk({p, "_other_ack"},  v.mst ? m0_ack : m1_ack, 1'b0);
    chk({p, "_rdata"},      v.mst ? m1_rdata : m0_rdata, v.exp_rdata);
    chk({p, "_other_rdata"}, v.mst ? m0_rdata : m1_rdata, 32'h0);
    chk({p, "_ram_en_resp"}, ram_en, 1'b0);
    drive(v.mst, 1'b0, v.addr, v.wdata, v.be);
  endtask

  // Random traffic state
  logic        rq[2];
  logic [31:0] ad[2];
  logic [31:0] wd[2];
  logic [3:0]  be[2];
  int          start_c[2];
  bit   [31:0] shadow [0:4095];

  task automatic new_txn(input int m);
    int r;
    r = $urandom_range(0, 9);
    if (r == 0)      ad[m] = 32'h0001_0000 | ($urandom_range(0, 7) << 2);
    else if (r == 1) ad[m] = 32'h0000_3FFC | $urandom_range(0, 3);
    else if (r == 2) ad[m] = 32'h8000_0000 | ($urandom_range(0, 7) << 2);
    else             ad[m] = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
    wd[m] = $urandom();
    be[m] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
  endtask

  initial begin
    int cyc, lg, free_c, acc_c, ack_c, win_m, w;
    bit acked[2];
    logic        acc_inr, exp_en;
    logic [11:0] acc_word;
    logic [3:0]  acc_be;
    logic [31:0] acc_wd, exp_rd;

    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 12'h004, 4'hF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 12'h004, 4'h0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b1, 12'h008, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_AB00, 4'h2, 1'b1, 12'h008, 4'h2, 32'h0};
    vecs[4]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 1'b1, 12'h008, 4'h0, 32'h1122_AB44};
    vecs[5]  = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 1'b0, 12'h000, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 12'h000, 4'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 1'b1, 12'h000, 4'h0, 32'h0};
    vecs[8]  = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF, 1'b1, 12'hFFF, 4'hF, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_3FFF, 32'h0,         4'h0, 1'b1, 12'hFFF, 4'h0, 32'hCAFE_F00D};
    vecs[10] = '{1'b0, 32'h0000_4000, 32'h0,         4'h0, 1'b0, 12'h000, 4'h0, 32'h0};
    vecs[11] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 1'b0, 12'h000, 4'h0, 32'h0};
    vecs[12] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b1, 12'h004, 4'h0, 32'hDEAD_BEEF};

    // Outputs while held in reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_m0_ack", m0_ack, 1'b0);
    chk("rst_m1_ack", m1_ack, 1'b0);
    chk("rst_m0_rdata", m0_rdata, 32'h0);
    chk("rst_m1_rdata", m1_rdata, 32'h0);
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_we", ram_we, 4'h0);
    chk("rst_ram_addr", ram_addr, 12'h0);
    chk("rst_ram_wdata", ram_wdata, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_vec(i, vecs[i]);
      @(negedge clk);
    end

    // Tie after reset: m0, m1, m0, m1 acks three cycles apart
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("rr_m0_ack_k%0d", k), m0_ack, (k == 2 || k == 8));
      chk($sformatf("rr_m1_ack_k%0d", k), m1_ack, (k == 5 || k == 11));
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);

    // Reset during the ACCESS cycle of an m1 write
    do_reset();
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h40, 32'h0000_0055, 4'hF);
    @(negedge clk);
    chk("rstacc_ram_en", ram_en, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("rstacc_m1_ack", m1_ack, 1'b0);
    chk("rstacc_ram_en_after", ram_en, 1'b0);
    chk("rstacc_ram_addr", ram_addr, 12'h0);
    chk("rstacc_ram_wdata", ram_wdata, 32'h0);
    @(negedge clk);
    chk("rstacc_m1_ack_late", m1_ack, 1'b0);
    chk("rstacc_ram_en_late", ram_en, 1'b0);
    drive(1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    chk("rstacc_tie_early", {30'b0, m1_ack, m0_ack}, 32'h0);
    @(negedge clk);
    chk("rstacc_tie_m0_ack", m0_ack, 1'b1);
    chk("rstacc_tie_m1_ack", m1_ack, 1'b0);
    chk("rstacc_tie_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);

    // Write data changed while the write is in flight
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h30, 32'h1111_1111, 4'hF);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h34, 32'h2222_2222, 4'hF);
    chk("inflight_ram_wdata", ram_wdata, 32'h1111_1111);
    chk("inflight_ram_addr", ram_addr, 12'h00C);
    @(negedge clk);
    chk("inflight_ack", m0_ack, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("inflight_mem", mem[12], 32'h1111_1111);
    chk("inflight_mem_next", mem[13], 32'h0);

    // Random traffic vs transaction-level reference
    do_reset();
    foreach (shadow[i]) shadow[i] = mem[i];
    for (int m = 0; m < 2; m++) begin
      rq[m] = 1'b0; ad[m] = '0; wd[m] = '0; be[m] = '0; start_c[m] = 0;
    end
    lg = 1; free_c = 0; acc_c = -1; ack_c = -1; win_m = 0;
    acc_inr = 1'b0; acc_word = '0; acc_be = '0; acc_wd = '0; exp_rd = '0;

    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      acked[0] = (ack_c == cyc) && (win_m == 0);
      acked[1] = (ack_c == cyc) && (win_m == 1);
      chk("rnd_m0_ack", m0_ack, acked[0]);
      chk("rnd_m1_ack", m1_ack, acked[1]);
      chk("rnd_m0_rdata", m0_rdata, acked[0] ? exp_rd : 32'h0);
      chk("rnd_m1_rdata", m1_rdata, acked[1] ? exp_rd : 32'h0);
      exp_en = (acc_c == cyc) && acc_inr;
      chk("rnd_ram_en", ram_en, exp_en);
      chk("rnd_ram_we", ram_we, exp_en ? acc_be : 4'h0);
      if (exp_en) chk("rnd_ram_addr", ram_addr, acc_word);
      if (exp_en && acc_be != 4'h0) chk("rnd_ram_wdata", ram_wdata, acc_wd);
      for (int m = 0; m < 2; m++)
        if (acked[m]) chk($sformatf("rnd_m%0d_wait", m), ((cyc - start_c[m]) <= 6), 1'b1);

      for (int m = 0; m < 2; m++) begin
        if (!rq[m] || acked[m]) begin
          if ($urandom_range(0, 3) != 0) begin
            new_txn(m);
            rq[m] = 1'b1;
            start_c[m] = acked[m] ? cyc + 1 : cyc;
          end else begin
            rq[m] = 1'b0;
          end
        end
      end

      if (cyc >= free_c && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) w = 1 - lg;
        else                w = rq[1] ? 1 : 0;
        lg = w; win_m = w;
        acc_inr  = (ad[w][31:14] == 18'h0);
        acc_word = ad[w][13:2];
        acc_be   = be[w];
        acc_wd   = wd[w];
        exp_rd   = 32'h0;
        if (acc_inr && acc_be == 4'h0) exp_rd = shadow[acc_word];
        if (acc_inr)
          for (int b = 0; b < 4; b++)
            if (acc_be[b]) shadow[acc_word][8*b +: 8] = acc_wd[8*b +: 8];
        acc_c = cyc + 1; ack_c = cyc + 2; free_c = cyc + 3;
      end

      for (int m = 0; m < 2; m++) drive(m[0], rq[m], ad[m], wd[m], be[m]);
    end

    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
